// File: rtl/pc_fetch_stage_pkg.sv
// Shared encodings and constants for the PC / IF-ID fetch stage.
// Optional supervisor masking is controlled by the PC_SUPERVISOR_EN macro.
package pc_fetch_stage_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_J   = 2'b10,
    PCSRC_JR  = 2'b11
  } pc_src_e;

  localparam logic [31:0] DEF_RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] DEF_ILLOP_PC  = 32'h8000_0004;
  localparam logic [31:0] DEF_XADR_PC   = 32'h8000_0008;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  function automatic logic [31:0] jump_target(input logic [31:0] pcplus4,
                                              input logic [25:0] jt);
    return {pcplus4[31:28], jt, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Control, instruction-memory and IF/ID signals of the fetch stage.
// master = fetch stage, slave = surrounding pipeline / memory.
interface pc_fetch_stage_if;
  logic [1:0]  pc_src;
  logic        redirect_req;
  logic        branch_taken;
  logic [31:0] ConBA;
  logic [25:0] jt;
  logic [31:0] databus_a;
  logic        irq;
  logic        exc;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pcplus4;
  logic        id_valid;
  logic [31:0] epc;
  logic        trap_taken;

  modport master (
    input  pc_src, redirect_req, branch_taken, ConBA, jt, databus_a, irq, exc, stall,
    input  imem_rdata,
    output imem_addr, id_instr, id_pcplus4, id_valid, epc, trap_taken
  );

  modport slave (
    output pc_src, redirect_req, branch_taken, ConBA, jt, databus_a, irq, exc, stall,
    output imem_rdata,
    input  imem_addr, id_instr, id_pcplus4, id_valid, epc, trap_taken
  );
endinterface

// File: rtl/pc_fetch_stage_pc_next_mux.sv
// Combinational redirect-target select and interrupt acceptance.
// PC_SUPERVISOR_EN: targets cannot set the kernel bit; irq only accepted in user mode.
module pc_fetch_stage_pc_next_mux
  import pc_fetch_stage_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  pc_src_i,
  input  logic        redirect_req_i,
  input  logic        branch_taken_i,
  input  logic [31:0] conba_i,
  input  logic [25:0] jt_i,
  input  logic [31:0] databus_a_i,
  input  logic        irq_i,
  output logic [31:0] pcplus4_o,
  output logic        redirect_o,
  output logic [31:0] target_o,
  output logic        irq_accept_o
);

  logic [31:0] pc4;

  always_comb begin
    pc4      = pc_i + 32'd4;
    target_o = pc4;
    unique case (pc_src_i)
      PCSRC_SEQ: target_o = pc4;
      PCSRC_BR:  target_o = conba_i;
      PCSRC_J:   target_o = jump_target(pc4, jt_i);
      PCSRC_JR:  target_o = databus_a_i;
      default:   target_o = pc4;
    endcase
`ifdef PC_SUPERVISOR_EN
    if (pc_src_i == PCSRC_BR || pc_src_i == PCSRC_J) begin
      target_o[31] = pc_i[31];
    end else if (pc_src_i == PCSRC_JR) begin
      target_o[31] = pc_i[31] & databus_a_i[31];
    end
    irq_accept_o = irq_i & ~pc_i[31];
`else
    irq_accept_o = irq_i;
`endif
    // A not-taken branch is just a sequential step, not a squashing redirect.
    redirect_o = redirect_req_i & ~((pc_src_i == PCSRC_BR) & ~branch_taken_i);
    pcplus4_o  = pc4;
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// PC register and IF/ID pipeline register with trap / redirect / stall priority.
// Optional macro PC_SUPERVISOR_EN enables kernel-bit masking in the next-PC mux.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] ILLOP_PC  = DEF_ILLOP_PC,
  parameter logic [31:0] XADR_PC   = DEF_XADR_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input logic              clk,
  input logic              reset,
  pc_fetch_stage_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;
  logic [31:0] epc_q, epc_d;
  logic        trap_q, trap_d;

  logic [31:0] pcplus4;
  logic        redirect;
  logic [31:0] target;
  logic        irq_accept;

  pc_fetch_stage_pc_next_mux u_mux (
    .pc_i           (pc_q),
    .pc_src_i       (bus.pc_src),
    .redirect_req_i (bus.redirect_req),
    .branch_taken_i (bus.branch_taken),
    .conba_i        (bus.ConBA),
    .jt_i           (bus.jt),
    .databus_a_i    (bus.databus_a),
    .irq_i          (bus.irq),
    .pcplus4_o      (pcplus4),
    .redirect_o     (redirect),
    .target_o       (target),
    .irq_accept_o   (irq_accept)
  );

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    epc_d     = epc_q;
    trap_d    = 1'b0;
    if (bus.exc) begin
      // Faulting instruction sits in decode; its address is id_pcplus4 - 4.
      pc_d      = XADR_PC;
      epc_d     = pcplus4_q - 32'd4;
      trap_d    = 1'b1;
      instr_d   = NOP_INSTR;
      pcplus4_d = '0;
      valid_d   = 1'b0;
    end else if (irq_accept) begin
      pc_d      = ILLOP_PC;
      epc_d     = pc_q;
      trap_d    = 1'b1;
      instr_d   = NOP_INSTR;
      pcplus4_d = '0;
      valid_d   = 1'b0;
    end else if (redirect) begin
      pc_d      = target;
      instr_d   = NOP_INSTR;
      pcplus4_d = '0;
      valid_d   = 1'b0;
    end else if (!bus.stall) begin
      pc_d      = pcplus4;
      instr_d   = bus.imem_rdata;
      pcplus4_d = pcplus4;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
      epc_q     <= '0;
      trap_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
      epc_q     <= epc_d;
      trap_q    <= trap_d;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.id_instr   = instr_q;
  assign bus.id_pcplus4 = pcplus4_q;
  assign bus.id_valid   = valid_q;
  assign bus.epc        = epc_q;
  assign bus.trap_taken = trap_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed self-checking bench for pc_fetch_stage (default and PC_SUPERVISOR_EN builds).
module tb_pc_fetch_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;
  logic [31:0] exp_base;

  localparam logic [31:0] RdXor = 32'h1234_5678;

  always #5 clk = ~clk;

  pc_fetch_stage_if bus ();

  pc_fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory model: word content derived from its address.
  assign bus.imem_rdata = bus.imem_addr ^ RdXor;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.redirect_req = 1'b0;
    bus.pc_src       = 2'b00;
    bus.branch_taken = 1'b0;
    bus.irq          = 1'b0;
    bus.exc          = 1'b0;
    bus.stall        = 1'b0;
  endtask

  initial begin
    idle();
    bus.ConBA     = '0;
    bus.jt        = '0;
    bus.databus_a = '0;
    reset         = 1'b1;
    step();
    reset = 1'b0;
    chk32("reset_addr", bus.imem_addr, 32'h8000_0000);
    chk1("reset_valid", bus.id_valid, 1'b0);
    chk32("reset_instr", bus.id_instr, 32'h0000_0000);
    chk32("reset_pc4", bus.id_pcplus4, 32'h0000_0000);
    chk32("reset_epc", bus.epc, 32'h0000_0000);
    chk1("reset_trap", bus.trap_taken, 1'b0);

    step();
    chk32("seq1_instr", bus.id_instr, 32'h9234_5678);
    chk1("seq1_valid", bus.id_valid, 1'b1);
    step();
    step();
    chk32("seq3_addr", bus.imem_addr, 32'h8000_000C);
    chk32("seq3_pc4", bus.id_pcplus4, 32'h8000_000C);
    chk32("seq3_instr", bus.id_instr, 32'h9234_5670);

    // Taken branch
    bus.redirect_req = 1'b1;
    bus.pc_src       = 2'b01;
    bus.branch_taken = 1'b1;
    bus.ConBA        = 32'h8000_0100;
    step();
    chk32("br_addr", bus.imem_addr, 32'h8000_0100);
    chk1("br_bubble", bus.id_valid, 1'b0);
    chk32("br_nop", bus.id_instr, 32'h0000_0000);
    idle();
    step();
    chk32("br_next_addr", bus.imem_addr, 32'h8000_0104);
    chk1("br_next_valid", bus.id_valid, 1'b1);
    chk32("br_next_pc4", bus.id_pcplus4, 32'h8000_0104);

    // Not-taken branch behaves as sequential
    bus.redirect_req = 1'b1;
    bus.pc_src       = 2'b01;
    bus.branch_taken = 1'b0;
    step();
    chk32("nt_addr", bus.imem_addr, 32'h8000_0108);
    chk1("nt_valid", bus.id_valid, 1'b1);
    chk32("nt_instr", bus.id_instr, 32'h9234_577C);
    chk32("nt_pc4", bus.id_pcplus4, 32'h8000_0108);

    // Two-cycle stall
    idle();
    bus.stall = 1'b1;
    step();
    step();
    chk32("stall_addr", bus.imem_addr, 32'h8000_0108);
    chk32("stall_instr", bus.id_instr, 32'h9234_577C);
    chk32("stall_pc4", bus.id_pcplus4, 32'h8000_0108);
    chk1("stall_valid", bus.id_valid, 1'b1);

    // Stall with jump redirect: redirect wins
    bus.redirect_req = 1'b1;
    bus.pc_src       = 2'b10;
    bus.jt           = 26'h000_0100;
    step();
    chk32("stall_jmp_addr", bus.imem_addr, 32'h8000_0400);
    chk1("stall_jmp_bubble", bus.id_valid, 1'b0);

    // JR to user address 0x40 (kernel bit clear in both builds)
    idle();
    bus.redirect_req = 1'b1;
    bus.pc_src       = 2'b11;
    bus.databus_a    = 32'h0000_0040;
    step();
    chk32("jr_user_addr", bus.imem_addr, 32'h0000_0040);

    // Interrupt in user mode
    idle();
    bus.irq = 1'b1;
    step();
    chk32("irq_addr", bus.imem_addr, 32'h8000_0004);
    chk32("irq_epc", bus.epc, 32'h0000_0040);
    chk1("irq_trap", bus.trap_taken, 1'b1);
    chk1("irq_bubble", bus.id_valid, 1'b0);
    bus.irq = 1'b0;
    step();
    chk1("irq_trap_pulse", bus.trap_taken, 1'b0);
    chk32("irq_after_addr", bus.imem_addr, 32'h8000_0008);

`ifdef PC_SUPERVISOR_EN
    // Kernel mode: irq must be ignored
    bus.irq = 1'b1;
    step();
    chk32("irq_kern_addr", bus.imem_addr, 32'h8000_000C);
    chk1("irq_kern_trap", bus.trap_taken, 1'b0);
    bus.irq = 1'b0;
`endif

    // JR to 0x1000, then JR to 0x8000_0200 from user mode
    bus.redirect_req = 1'b1;
    bus.pc_src       = 2'b11;
    bus.databus_a    = 32'h0000_1000;
    step();
    chk32("jr_1000", bus.imem_addr, 32'h0000_1000);
    bus.databus_a = 32'h8000_0200;
    step();
`ifdef PC_SUPERVISOR_EN
    exp_base = 32'h0000_0200;
`else
    exp_base = 32'h8000_0200;
`endif
    chk32("jr_kbit", bus.imem_addr, exp_base);

    // One sequential fetch, then exc + irq together
    idle();
    step();
    chk32("pre_exc_pc4", bus.id_pcplus4, exp_base + 32'd4);
    chk32("pre_exc_instr", bus.id_instr, exp_base ^ RdXor);
    bus.exc = 1'b1;
    bus.irq = 1'b1;
    step();
    chk32("exc_addr", bus.imem_addr, 32'h8000_0008);
    chk32("exc_epc", bus.epc, exp_base);
    chk1("exc_trap", bus.trap_taken, 1'b1);
    chk1("exc_bubble", bus.id_valid, 1'b0);

    // 32-bit wrap of PC+4
    idle();
    bus.redirect_req = 1'b1;
    bus.pc_src       = 2'b11;
    bus.databus_a    = 32'hFFFF_FFFC;
    step();
    chk32("wrap_jr", bus.imem_addr, 32'hFFFF_FFFC);
    idle();
    step();
    chk32("wrap_addr", bus.imem_addr, 32'h0000_0000);
    chk32("wrap_pc4", bus.id_pcplus4, 32'h0000_0000);
    chk32("wrap_instr", bus.id_instr, 32'hFFFF_FFFC ^ RdXor);

    // Reset during stall
    bus.stall = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk32("rst_stall_addr", bus.imem_addr, 32'h8000_0000);
    chk1("rst_stall_valid", bus.id_valid, 1'b0);
    chk32("rst_stall_epc", bus.epc, 32'h0000_0000);
    chk32("rst_stall_pc4", bus.id_pcplus4, 32'h0000_0000);

    // Reset during redirect
    idle();
    bus.redirect_req = 1'b1;
    bus.pc_src       = 2'b10;
    reset            = 1'b1;
    step();
    reset = 1'b0;
    idle();
    chk32("rst_redir_addr", bus.imem_addr, 32'h8000_0000);
    chk1("rst_redir_trap", bus.trap_taken, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
